handshake_requester: RTL and testbench

- Upstream issuer for the request/accept/done handshake controller.
- Buffers incoming data words in a small FIFO.
- Raises `request`, streams up to BURST_MAX buffered words during the cycles `accept` is high, then drops `request` and waits for the single-cycle `done` pulse before starting the next burst.
- Sits between the data source and the handshake controller; `out_data`/`out_valid` feed the consuming datapath.

---
 rtl/handshake_requester.sv | 124 ++++++++++++
 tb/tb_handshake_requester.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_requester.sv
// rtl/handshake_requester.sv - FIFO-buffered burst issuer for the request/accept/done handshake
// Optional macro DONE_TIMEOUT_EN: abort WAIT_DONE after TIMEOUT cycles with a timeout_err pulse.
module handshake_requester #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              request,
    input  logic              accept,
    input  logic              done,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_MAX + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BURST_MAX < 1 || TIMEOUT < 1) begin : g_param_check
        $error("handshake_requester: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [BW-1:0]     beat;
    logic              push, pop, last_beat, abort;

    assign in_ready  = (count != CW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign pop       = (state == REQ) & accept & (count != '0);
    // A push in the same cycle never extends the burst: the decision uses the registered count.
    assign last_beat = pop & ((beat == BW'(BURST_MAX - 1)) | (count == CW'(1)));
    assign busy      = (state != IDLE);

`ifdef DONE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    // done in the expiry cycle wins over the abort.
    assign abort = (state == WAIT_DONE) & ~done & (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (state != WAIT_DONE) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + TW'(1);
            end
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (count != '0) state_nxt = REQ;
            REQ:       if (last_beat) state_nxt = WAIT_DONE;
            WAIT_DONE: if (done || abort) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            request   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            beat      <= '0;
        end else begin
            state     <= state_nxt;
            request   <= (state_nxt == REQ);
            out_valid <= pop;
            if (pop) begin
                out_data <= mem[rd_ptr];
            end
            if (state == IDLE) begin
                beat <= '0;
            end else if (pop) begin
                beat <= beat + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end
endmodule

// File: tb/tb_handshake_requester.sv
// tb/tb_handshake_requester.sv - scoreboard bench for handshake_requester with a controller model
`timescale 1ns/1ps
module tb_handshake_requester;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int BURST_MAX = 4;
    localparam int TIMEOUT   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              request;
    logic              accept;
    logic              done;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              timeout_err;

    handshake_requester #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .request(request), .accept(accept), .done(done), .out_valid(out_valid),
        .out_data(out_data), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    int  runs[$];
    int  cyc, ov_total, run_len, stall, terr_count, terr_cyc, wait_entry, run1;
    bit  auto_acc, auto_done, h1, h2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: record the push, step the edge, score outputs, then play the controller.
    task automatic cycle();
        if (in_valid && in_ready) exp_q.push_back(in_data);
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            ov_total++;
            run_len++;
            if (exp_q.size() == 0) check("out_unexpected", 1, 0);
            else check("out_data", out_data, exp_q.pop_front());
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        check("in_ready", in_ready, exp_q.size() < DEPTH);
        if (timeout_err) begin
            terr_count++;
            terr_cyc = cyc;
        end
        if (h1 && !request) wait_entry = cyc;
        if (auto_acc)  accept = (run1 > stall);
        if (auto_done) done = h2 && !h1;
        h2   = h1;
        h1   = request;
        run1 = request ? run1 + 1 : 0;
    endtask

    task automatic drain(input int max_cyc);
        int i;
        in_valid  = 1'b0;
        auto_acc  = 1'b1;
        auto_done = 1'b1;
        stall     = 0;
        i = 0;
        while (i < max_cyc && !(exp_q.size() == 0 && !busy)) begin
            cycle();
            i++;
        end
        check("drain_idle", (exp_q.size() == 0) && !busy && !request, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] d;
        bit pushed;
        int ov0, e, first_ov;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; accept = 1'b0; done = 1'b0;
        cyc = 0; ov_total = 0; run_len = 0; stall = 0; terr_count = 0; terr_cyc = -1;
        wait_entry = -1; run1 = 0; h1 = 1'b0; h2 = 1'b0; auto_acc = 1'b1; auto_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_request", request, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        repeat (2) cycle();

        // Single word: request cycles 2..3, one beat, idle after done.
        cyc = 0; ov0 = ov_total;
        in_valid = 1'b1; in_data = 8'hA5;
        cycle();
        in_valid = 1'b0;
        check("single_req_c1", request, 0);
        cycle(); check("single_req_c2", request, 1);
        cycle(); check("single_req_c3", request, 1);
        cycle(); check("single_req_c4", request, 0); check("single_ov_c4", out_valid, 1);
        cycle();
        cycle(); check("single_busy_c6", busy, 0);
        check("single_beats", ov_total - ov0, 1);
        drain(20);

        // Full-burst limit: six words split 4 + 2.
        runs.delete(); run_len = 0; ov0 = ov_total; d = 8'h01;
        for (int i = 0; i < 30 && d != 8'h07; i++) begin
            in_valid = 1'b1; in_data = d; pushed = in_ready;
            cycle();
            if (pushed) d++;
        end
        drain(60);
        check("burst_words", ov_total - ov0, 6);
        check("burst_runs", runs.size(), 2);
        if (runs.size() == 2) begin
            check("burst1_len", runs[0], 4);
            check("burst2_len", runs[1], 2);
        end

        // Stalled accept: FIFO fills, request held, pop on first accept cycle.
        cyc = 0; stall = 5; first_ov = -1; d = 8'h11;
        for (int i = 0; i < 60 && !(d == 8'h16 && exp_q.size() == 0 && !busy); i++) begin
            in_valid = (d != 8'h16); in_data = d; pushed = in_valid && in_ready;
            cycle();
            if (pushed) d++;
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (cyc >= 2 && cyc <= 7) begin
                check("stall_req", request, 1);
                check("stall_ov", out_valid, 0);
            end
            if (cyc == 5) check("stall_full", in_ready, 0);
        end
        check("stall_first_pop", first_ov, 9);
        drain(40);

        // Spurious done/accept are ignored outside their states.
        auto_acc = 1'b0; auto_done = 1'b0; accept = 1'b0; done = 1'b0; ov0 = ov_total;
        done = 1'b1; accept = 1'b1;
        cycle();
        done = 1'b0; accept = 1'b0;
        cycle();
        check("spur_idle_busy", busy, 0);
        check("spur_idle_req", request, 0);
        in_valid = 1'b1; in_data = 8'h3C;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("spur_req_up", request, 1);
        done = 1'b1;
        cycle();
        done = 1'b0;
        cycle();
        check("spur_req_hold", request, 1);
        check("spur_req_nopop", ov_total - ov0, 0);
        accept = 1'b1;
        cycle();
        in_valid = 1'b1; in_data = 8'h3D;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        accept = 1'b0;
        check("spur_wait_req", request, 0);
        check("spur_wait_busy", busy, 1);
        check("spur_wait_nopop", ov_total - ov0, 1);
        done = 1'b1;
        cycle();
        done = 1'b0;
        drain(30);

        // Reset mid-burst discards everything.
        ov0 = ov_total;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h41 + 8'(i);
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && (ov_total - ov0) < 2; i++) cycle();
        check("rstmid_two_beats", ov_total - ov0, 2);
        #3;
        rst = 1'b1;
        #1;
        check("rstmid_request", request, 0);
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_busy", busy, 0);
        exp_q.delete();
        accept = 1'b0; done = 1'b0; h1 = 1'b0; h2 = 1'b0; run1 = 0; run_len = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ov0 = ov_total;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rstmid_quiet_req", request, 0);
        end
        check("rstmid_quiet_ov", ov_total - ov0, 0);
        in_valid = 1'b1; in_data = 8'h55;
        cycle();
        drain(20);
        check("rstmid_new_word", ov_total - ov0, 1);

        // Withheld done after a burst, with one word waiting behind it.
        auto_done = 1'b0; wait_entry = -1; terr_count = 0; cyc = 0;
        in_valid = 1'b1; in_data = 8'h70;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && wait_entry < 0; i++) cycle();
        check("to_wait_entry", wait_entry, 4);
        e = wait_entry;
        in_valid = 1'b1; in_data = 8'h71;
        cycle();
        in_valid = 1'b0;
`ifdef DONE_TIMEOUT_EN
        while (cyc < e + 18) begin
            cycle();
            if (cyc == e + 16) check("to_idle_after_abort", busy, 0);
            if (cyc == e + 17) check("to_rerequest", request, 1);
        end
        check("to_err_pulses", terr_count, 1);
        check("to_err_cycle", terr_cyc, e + 16);
`else
        while (cyc < e + 20) begin
            cycle();
            if (cyc == e + 16 || cyc == e + 20) check("nto_still_waiting", busy, 1);
        end
        check("nto_no_err", terr_count, 0);
        done = 1'b1;
        cycle();
        done = 1'b0;
`endif
        drain(40);

        // done arriving in the expiry cycle is a success.
        auto_done = 1'b0; wait_entry = -1; terr_count = 0; cyc = 0;
        in_valid = 1'b1; in_data = 8'h72;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && wait_entry < 0; i++) cycle();
        check("late_wait_entry", wait_entry, 4);
        e = wait_entry;
        in_valid = 1'b1; in_data = 8'h73;
        cycle();
        in_valid = 1'b0;
        while (cyc < e + 17) begin
            done = (cyc == e + 15);
            cycle();
            if (cyc == e + 16) check("late_done_idle", busy, 0);
        end
        done = 1'b0;
        check("late_done_no_err", terr_count, 0);
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
